// File: rtl/ps2_hex_entry.sv
// rtl/ps2_hex_entry.sv - PS/2 scancode to hex-nibble entry front end for the 128-bit key/data store
//
// Purpose:
//   Tracks PS/2 make/break/extended prefixes. Turns hex key make codes into
//   nibble writes at a cursor, and handles Backspace, Esc (clear) and Enter (done).
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   scancode       in   [7:0] PS/2 byte from the receiver
//   scancode_valid in   one-cycle strobe qualifying scancode
//   ps2data_out    out  [3:0] nibble to write to the store (holds when idle)
//   index          out  [IDX_W-1:0] store nibble address (holds when idle)
//   write_enable   out  one-cycle store write pulse
//   clear_store    out  one-cycle pulse on Esc
//   entry_count    out  [IDX_W:0] nibbles entered, 0..NUM_NIBBLES
//   full           out  high while entry_count == NUM_NIBBLES
//   entry_done     out  level, high from Enter until Esc or reset
//
// Build option:
//   KEYPAD_HEX_EN  when defined, numeric keypad make codes also enter digits 0-9.

module ps2_hex_entry #(
    parameter int NUM_NIBBLES = 32,
    parameter int IDX_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       scancode,
    input  logic             scancode_valid,
    output logic [3:0]       ps2data_out,
    output logic [IDX_W-1:0] index,
    output logic             write_enable,
    output logic             clear_store,
    output logic [IDX_W:0]   entry_count,
    output logic             full,
    output logic             entry_done
);

    localparam logic [IDX_W:0] CAP = (IDX_W+1)'(NUM_NIBBLES);

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [2:0] {
        S_ENTRY,
        S_BRK,
        S_EXT,
        S_EXT_BRK,
        S_DONE
    } state_t;

    state_t           r_state, w_state_n;
    logic             r_ret_done, w_ret_done_n;   // prefix states return to DONE when set
    logic [IDX_W:0]   r_cursor, w_cursor_n;
    logic [3:0]       r_data, w_data_n;
    logic [IDX_W-1:0] r_index, w_index_n;
    logic             r_we, w_we_n;
    logic             r_clr, w_clr_n;
    logic             r_full, w_full_n;
    logic             r_done, w_done_n;

    logic             w_is_hex;
    logic [3:0]       w_nibble;

    // Scancode to nibble lookup
    always_comb begin
        w_is_hex = 1'b1;
        w_nibble = 4'h0;
        case (scancode)
            8'h45: w_nibble = 4'h0;
            8'h16: w_nibble = 4'h1;
            8'h1E: w_nibble = 4'h2;
            8'h26: w_nibble = 4'h3;
            8'h25: w_nibble = 4'h4;
            8'h2E: w_nibble = 4'h5;
            8'h36: w_nibble = 4'h6;
            8'h3D: w_nibble = 4'h7;
            8'h3E: w_nibble = 4'h8;
            8'h46: w_nibble = 4'h9;
            8'h1C: w_nibble = 4'hA;
            8'h32: w_nibble = 4'hB;
            8'h21: w_nibble = 4'hC;
            8'h23: w_nibble = 4'hD;
            8'h24: w_nibble = 4'hE;
            8'h2B: w_nibble = 4'hF;
`ifdef KEYPAD_HEX_EN
            8'h70: w_nibble = 4'h0;
            8'h69: w_nibble = 4'h1;
            8'h72: w_nibble = 4'h2;
            8'h7A: w_nibble = 4'h3;
            8'h6B: w_nibble = 4'h4;
            8'h73: w_nibble = 4'h5;
            8'h74: w_nibble = 4'h6;
            8'h6C: w_nibble = 4'h7;
            8'h75: w_nibble = 4'h8;
            8'h7D: w_nibble = 4'h9;
`endif
            default: w_is_hex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_ENTRY;
            r_ret_done <= 1'b0;
            r_cursor   <= '0;
            r_data     <= '0;
            r_index    <= '0;
            r_we       <= 1'b0;
            r_clr      <= 1'b0;
            r_full     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_ret_done <= w_ret_done_n;
            r_cursor   <= w_cursor_n;
            r_data     <= w_data_n;
            r_index    <= w_index_n;
            r_we       <= w_we_n;
            r_clr      <= w_clr_n;
            r_full     <= w_full_n;
            r_done     <= w_done_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_ret_done_n = r_ret_done;
        w_cursor_n   = r_cursor;
        w_data_n     = r_data;
        w_index_n    = r_index;
        w_we_n       = 1'b0;
        w_clr_n      = 1'b0;
        w_done_n     = r_done;

        if (scancode_valid) begin
            case (r_state)
                S_ENTRY, S_DONE: begin
                    if (scancode == SC_BREAK) begin
                        w_state_n    = S_BRK;
                        w_ret_done_n = (r_state == S_DONE);
                    end else if (scancode == SC_EXT) begin
                        w_state_n    = S_EXT;
                        w_ret_done_n = (r_state == S_DONE);
                    end else if (scancode == SC_ESC) begin
                        w_state_n  = S_ENTRY;
                        w_clr_n    = 1'b1;
                        w_cursor_n = '0;
                        w_done_n   = 1'b0;
                    end else if (r_state == S_ENTRY) begin
                        if (scancode == SC_ENTER) begin
                            w_state_n = S_DONE;
                            w_done_n  = 1'b1;
                        end else if (scancode == SC_BKSP) begin
                            if (r_cursor != '0) begin
                                w_cursor_n = r_cursor - (IDX_W+1)'(1);
                                w_we_n     = 1'b1;
                                w_data_n   = 4'h0;
                                // Low bits minus one wraps correctly when cursor == NUM_NIBBLES
                                w_index_n  = r_cursor[IDX_W-1:0] - IDX_W'(1);
                            end
                        end else if (w_is_hex && (r_cursor < CAP)) begin
                            w_cursor_n = r_cursor + (IDX_W+1)'(1);
                            w_we_n     = 1'b1;
                            w_data_n   = w_nibble;
                            w_index_n  = r_cursor[IDX_W-1:0];
                        end
                    end
                end
                S_EXT: begin
                    if (scancode == SC_BREAK) begin
                        w_state_n = S_EXT_BRK;
                    end else begin
                        w_state_n = r_ret_done ? S_DONE : S_ENTRY;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    w_state_n = r_ret_done ? S_DONE : S_ENTRY;
                end
                default: begin
                    w_state_n = S_ENTRY;
                end
            endcase
        end

        // full is registered alongside the cursor so both move on the same edge
        w_full_n = (w_cursor_n == CAP);
    end

    assign ps2data_out  = r_data;
    assign index        = r_index;
    assign write_enable = r_we;
    assign clear_store  = r_clr;
    assign entry_count  = r_cursor;
    assign full         = r_full;
    assign entry_done   = r_done;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// tb/tb_ps2_hex_entry.sv - self-checking bench for ps2_hex_entry with a behavioural model

module tb_ps2_hex_entry;

    localparam int N  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    scancode;
    logic          scancode_valid;
    logic [3:0]    ps2data_out;
    logic [IW-1:0] index;
    logic          write_enable;
    logic          clear_store;
    logic [IW:0]   entry_count;
    logic          full;
    logic          entry_done;

    ps2_hex_entry #(.NUM_NIBBLES(N), .IDX_W(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .ps2data_out    (ps2data_out),
        .index          (index),
        .write_enable   (write_enable),
        .clear_store    (clear_store),
        .entry_count    (entry_count),
        .full           (full),
        .entry_done     (entry_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int wlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a skip counter for break prefixes, a flag for a pending E0
    typedef struct {
        int cursor;
        bit done;
        int skip;
        bit extw;
        bit we;
        bit clr;
        int data;
        int idx;
    } model_s;

    model_s m;

    function automatic int hexval(input logic [7:0] b);
        logic [7:0] codes[16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
`ifdef KEYPAD_HEX_EN
        logic [7:0] kp[10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
        for (int i = 0; i < 10; i++) if (kp[i] == b) return i;
`endif
        for (int i = 0; i < 16; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    function automatic model_s step(input model_s c, input logic v, input logic [7:0] b);
        model_s n = c;
        int hv;
        n.we  = 1'b0;
        n.clr = 1'b0;
        if (!v) return n;
        hv = hexval(b);
        if (c.extw) begin
            n.extw = 1'b0;
            if (b == 8'hF0) n.skip = 1;
        end else if (c.skip > 0) begin
            n.skip = c.skip - 1;
        end else if (b == 8'hF0) begin
            n.skip = 1;
        end else if (b == 8'hE0) begin
            n.extw = 1'b1;
        end else if (b == 8'h76) begin
            n.clr = 1'b1; n.cursor = 0; n.done = 1'b0;
        end else if (!c.done) begin
            if (b == 8'h5A) begin
                n.done = 1'b1;
            end else if (b == 8'h66) begin
                if (c.cursor > 0) begin
                    n.cursor = c.cursor - 1; n.we = 1'b1; n.data = 0; n.idx = c.cursor - 1;
                end
            end else if (hv >= 0 && c.cursor < N) begin
                n.we = 1'b1; n.data = hv; n.idx = c.cursor; n.cursor = c.cursor + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m <= '{cursor: 0, done: 1'b0, skip: 0, extw: 1'b0, we: 1'b0, clr: 1'b0, data: 0, idx: 0};
        end else begin
            m <= step(m, scancode_valid, scancode);
        end
    end

    always @(negedge clk) begin
        chk("write_enable", write_enable, m.we);
        chk("clear_store", clear_store, m.clr);
        chk("ps2data_out", ps2data_out, m.data);
        chk("index", index, m.idx);
        chk("entry_count", entry_count, m.cursor);
        chk("full", full, (m.cursor == N));
        chk("entry_done", entry_done, m.done);
        if (write_enable === 1'b1) wlog.push_back(int'(ps2data_out) * 256 + int'(index));
    end

    task automatic drive(input logic [7:0] b);
        @(posedge clk); #1;
        scancode       = b;
        scancode_valid = 1'b1;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            scancode_valid = 1'b0;
            scancode       = 8'($urandom);
        end
    endtask

    task automatic send(input logic [7:0] b);
        drive(b);
        quiet(1);
    endtask

    function automatic logic [7:0] rand_code();
        logic [7:0] hx[16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
        logic [7:0] kp[10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
        int r = $urandom_range(0, 99);
        if (r < 45) return hx[$urandom_range(0, 15)];
        if (r < 55) return 8'h66;
        if (r < 60) return 8'h5A;
        if (r < 64) return 8'h76;
        if (r < 71) return 8'hF0;
        if (r < 76) return 8'hE0;
        if (r < 82) return kp[$urandom_range(0, 9)];
        return 8'($urandom);
    endfunction

    int base;

    initial begin
        reset          = 1'b1;
        scancode       = 8'h00;
        scancode_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_entry_count", entry_count, 0);
        chk("reset_write_enable", write_enable, 0);
        reset = 1'b0;
        quiet(2);

        // 1, 2, A
        send(8'h16); quiet(2);
        send(8'h1E); quiet(2);
        send(8'h1C); quiet(2);
        chk("lit_wlog_size", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("lit_w0", wlog[0], 32'h100);
            chk("lit_w1", wlog[1], 32'h201);
            chk("lit_w2", wlog[2], 32'hA02);
        end
        chk("lit_count3", entry_count, 3);

        // Break and extended sequences write nothing
        send(8'hF0); send(8'h16); quiet(2);
        drive(8'hE0); drive(8'h1C); quiet(1);
        drive(8'hE0); drive(8'hF0); drive(8'h1C); quiet(2);
        chk("lit_prefix_nowrite", wlog.size(), 3);
        chk("lit_prefix_count", entry_count, 3);

        // Backspace at count 3
        send(8'h66); quiet(2);
        chk("lit_bksp_write", wlog[$], 32'h002);
        chk("lit_bksp_count", entry_count, 2);

        // Esc then Backspace at 0
        send(8'h76); quiet(1);
        base = wlog.size();
        send(8'h66); quiet(2);
        chk("lit_bksp0_nowrite", wlog.size(), base);
        chk("lit_bksp0_count", entry_count, 0);

        // Fill to capacity, then one extra
        for (int i = 0; i < N; i++) send(8'h2B);
        send(8'h2B); quiet(2);
        chk("lit_fill_writes", wlog.size(), base + N);
        chk("lit_fill_last", wlog[$], 32'hF1F);
        chk("lit_full", full, 1);
        chk("lit_full_count", entry_count, N);

        // Enter then hex ignored, Esc clears
        base = wlog.size();
        send(8'h5A); send(8'h16); quiet(2);
        chk("lit_done", entry_done, 1);
        chk("lit_done_nowrite", wlog.size(), base);
        send(8'h76); quiet(2);
        chk("lit_esc_done", entry_done, 0);
        chk("lit_esc_count", entry_count, 0);

        // Reset after F0
        send(8'h16); send(8'hF0);
        @(posedge clk); #1 reset = 1'b1;
        #2;
        chk("lit_rst_count", entry_count, 0);
        chk("lit_rst_data", ps2data_out, 0);
        chk("lit_rst_index", index, 0);
        @(posedge clk); #1 reset = 1'b0;
        send(8'h16); quiet(2);
        chk("lit_after_rst", wlog[$], 32'h100);

        // Keypad digit
        base = wlog.size();
        send(8'h69); quiet(2);
`ifdef KEYPAD_HEX_EN
        chk("lit_keypad", wlog.size(), base + 1);
        chk("lit_keypad_val", wlog[$], 32'h101);
`else
        chk("lit_keypad", wlog.size(), base);
        chk("lit_keypad_count", entry_count, 1);
`endif

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive(rand_code());
            if ($urandom_range(0, 3) != 0) quiet($urandom_range(1, 3));
            if (i % 700 == 350) begin
                @(posedge clk); #1 reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
            end
        end
        quiet(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_hex_entry.md
Name: ps2_hex_entry

Overview:
- Keyboard-entry front end for the 128-bit key/data store.
- Consumes decoded PS/2 scancode bytes and tracks make/break/extended prefixes.
- Converts hex keys to nibbles and drives the store's nibble, index and write-enable inputs.
- Handles cursor, backspace, clear and Enter; signals the encrypt/decrypt datapath when entry completes.

Parameters:
- NUM_NIBBLES, 32, store capacity in nibbles; cursor saturates here.
- IDX_W, 5, width of index output; must satisfy 2^IDX_W >= NUM_NIBBLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- scancode  input  8  PS/2 byte from the receiver.
- scancode_valid  input  1  one-cycle strobe qualifying scancode; back-to-back strobes legal.
- ps2data_out  output  4  hex nibble to write to the store.
- index  output  IDX_W  store nibble address for the current write.
- write_enable  output  1  one-cycle store write pulse.
- clear_store  output  1  one-cycle pulse on Esc; ORed into the store reset.
- entry_count  output  IDX_W+1  nibbles entered, 0..NUM_NIBBLES.
- full  output  1  high while entry_count == NUM_NIBBLES.
- entry_done  output  1  level; high from Enter until Esc or reset.

Behaviour:
- Reset (async, any state): FSM=ENTRY; cursor=0; all outputs 0.
- FSM states: ENTRY, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0), DONE.
- Prefix transitions:
  - ENTRY/DONE + F0 -> BRK.
  - ENTRY/DONE + E0 -> EXT.
  - BRK + any byte -> return state; byte discarded.
  - EXT + F0 -> EXT_BRK.
  - EXT + other byte -> return state; byte discarded.
  - EXT_BRK + any byte -> return state; byte discarded.
- A 1-bit return register records ENTRY vs DONE for prefix states.
- Only make codes are acted on. Extended keys are ignored. Typematic repeats act as repeated presses.
- Hex map:
  - 0=45, 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46.
  - A=1C, B=32, C=21, D=23, E=24, F=2B.
- Hex make in ENTRY with cursor < NUM_NIBBLES (strobe at cycle T):
  - T+1: write_enable=1, ps2data_out=nibble, index=cursor.
  - T+1: cursor and entry_count increment.
  - Latency is one cycle.
- Hex make when full: ignored; no write.
- Backspace (66) in ENTRY, cursor > 0:
  - T+1: cursor decrements.
  - T+1: write_enable=1, ps2data_out=0, index=cursor-1.
  - At cursor 0: ignored.
- Enter (5A) in ENTRY: FSM -> DONE, entry_done=1 at T+1. Accepted at any count, including 0.
- Esc (76) in ENTRY or DONE:
  - T+1: clear_store=1 for one cycle; cursor=0; entry_done=0; FSM -> ENTRY.
  - No write_enable.
- DONE: hex, Backspace and Enter ignored; only Esc and prefixes act.
- All other codes: ignored.
- write_enable and clear_store are never high in the same cycle.
- ps2data_out and index hold their last values when write_enable=0.
- full and entry_count are registered and track cursor in the same cycle as it updates.
- scancode is ignored when scancode_valid=0.

Optional Feature:
- KEYPAD_HEX_EN. Defined: numeric keypad make codes are accepted as digits with identical timing.
  - 0=70, 1=69, 2=72, 3=7A, 4=6B, 5=73, 6=74, 7=6C, 8=75, 9=7D.
- Undefined: those codes are ignored like any unmapped code.

Test Plan:
- Type 1,2,A (16,1E,1C, 3 cycles apart) -> write_enable pulses with (nibble,index) = (1,0),(2,1),(A,2); entry_count=3.
- Send F0,16 after the above -> no write; entry_count stays 3.
- Send E0,1C and E0,F0,1C -> no write; FSM returns to ENTRY.
- Enter 32 digits F, then one more 2B -> 32 writes at index 0..31; full=1; 33rd key produces no write.
- Backspace:
  - At count 3 -> write (0, index 2); entry_count=2.
  - At count 0 -> no output.
- Enter then 16 -> entry_done=1, no write. Then 76 -> clear_store pulse, entry_done=0, entry_count=0.
- Assert reset mid-sequence, after F0 -> all outputs 0. Next 16 writes (1, index 0).
- With KEYPAD_HEX_EN, send 69 -> write (1, index 0). Without it, send 69 -> no write.
